// File: rtl/timer_sched_pkg.sv
// Shared types and default sizing for the timer scheduler and its counter.
package timer_sched_pkg;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_NUM_CNT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover value and a registered rollover flag.
module flex_counter
    import timer_sched_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_next;
    logic                    r_flag;

    always_comb begin
        w_next = r_count;
        if (clear) begin
            w_next = '0;
        end else if (count_enable) begin
            if (r_count == rollover_val) begin
                w_next = NUM_CNT_BITS'(1);
            end else begin
                w_next = r_count + NUM_CNT_BITS'(1);
            end
        end
    end

    // Flag is computed from the next value so it is high while count_out equals rollover_val.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_flag  <= (w_next == rollover_val);
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin arbiter that time-shares one flex_counter among NUM_REQ requesters,
// returning a one-cycle done pulse to the winner when its latched interval elapses.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter  int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS,
    localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_len,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic [ID_W-1:0]                 active_id,
    output logic [NUM_CNT_BITS-1:0]         count_out
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_active_id;
    logic [ID_W-1:0]         w_win_id;
    logic [ID_W-1:0]         w_ptr_next;
    logic                    w_any_req;
    logic                    w_abort;
    logic                    w_clear;
    logic                    w_count_en;
    logic                    w_rollover;
    logic                    w_n_rst;
    logic [NUM_CNT_BITS-1:0] r_len;
    logic [NUM_CNT_BITS-1:0] w_len_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      r_done;
    logic                    r_busy;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign w_len_arr[g] = req_len[g*NUM_CNT_BITS +: NUM_CNT_BITS];
    end

    // Scan downward so the last hit is the first set bit at or after the pointer.
    always_comb begin
        w_any_req = 1'b0;
        w_win_id  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[ID_W'((32'(r_ptr) + 32'(i)) % NUM_REQ)]) begin
                w_any_req = 1'b1;
                w_win_id  = ID_W'((32'(r_ptr) + 32'(i)) % NUM_REQ);
            end
        end
    end

    assign w_abort    = ((r_state == LOAD) || (r_state == COUNT)) && !req[r_active_id];
    assign w_ptr_next = (32'(r_active_id) == NUM_REQ - 1) ? '0 : r_active_id + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = LOAD;
            LOAD: begin
                if (w_abort)               w_next_state = IDLE;
                else if (r_len == '0)      w_next_state = DONE;
                else                       w_next_state = COUNT;
            end
            COUNT: begin
                if (w_abort)               w_next_state = IDLE;
                else if (w_rollover)       w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Counter controls; an abort clears so the next service starts from zero.
    always_comb begin
        w_clear    = 1'b0;
        w_count_en = 1'b0;
        case (r_state)
            LOAD:  w_clear = 1'b1;
            COUNT: begin
                if (w_abort) w_clear    = 1'b1;
                else         w_count_en = !w_rollover;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_active_id <= '0;
            r_len       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= '0;
            if ((r_state == IDLE) && w_any_req) begin
                r_grant     <= NUM_REQ'(1) << w_win_id;
                r_active_id <= w_win_id;
                r_len       <= w_len_arr[w_win_id];
            end
            if (w_next_state == DONE) begin
                r_done <= NUM_REQ'(1) << r_active_id;
            end
            if ((r_state == DONE) || w_abort) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
            end
        end
    end

    assign w_n_rst = ~rst;

    flex_counter #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_counter (
        .clk           (clk),
        .n_rst         (w_n_rst),
        .clear         (w_clear),
        .count_enable  (w_count_en),
        .rollover_val  (r_len),
        .count_out     (count_out),
        .rollover_flag (w_rollover)
    );

    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign active_id = r_active_id;

endmodule
